// File: rtl/simmem_delay_release_scheduler.sv
// Per-ID head-delay counters feeding a locked valid/ready release arbiter.
// Define SIMMEM_DELAY_SCHED_RR_EN for round-robin arbitration; otherwise lowest eligible index wins.
module simmem_delay_release_scheduler #(
  parameter int NumIds       = 16,
  parameter int DelayWidth   = 8,
  parameter int CounterWidth = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic [NumIds-1:0][DelayWidth-1:0]  delay_i,
  input  logic [NumIds-1:0]                  delay_valid_i,
  output logic                               out_valid_o,
  output logic [NumIds-1:0]                  out_id_onehot_o,
  input  logic                               out_ready_i,
  output logic [NumIds-1:0]                  released_onehot_o
);
  localparam int IdxW = $clog2(NumIds);

  if (CounterWidth < DelayWidth) begin : g_bad_counter_width
    $error("CounterWidth must be at least DelayWidth");
  end
  if (NumIds < 2) begin : g_bad_num_ids
    $error("NumIds must be at least 2");
  end

  function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NumIds) s = s - NumIds;
    return IdxW'(s);
  endfunction

  logic [NumIds-1:0][CounterWidth-1:0] r_cnt;
  logic                                r_lock;
  logic [IdxW-1:0]                     r_lock_idx;
  logic [NumIds-1:0]                   w_elig;
  logic [IdxW-1:0]                     w_start;
  logic [IdxW-1:0]                     w_arb_idx;
  logic                                w_found;
  logic [IdxW-1:0]                     w_grant_idx;
  logic                                w_valid;
  logic                                w_active;

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      w_elig[i] = delay_valid_i[i] && (r_cnt[i] >= CounterWidth'(delay_i[i]));
    end
  end

  // First eligible index at or after w_start, wrapping around
  always_comb begin
    w_found   = 1'b0;
    w_arb_idx = '0;
    for (int k = 0; k < NumIds; k++) begin
      if (!w_found && w_elig[wrap_idx(w_start, k)]) begin
        w_found   = 1'b1;
        w_arb_idx = wrap_idx(w_start, k);
      end
    end
  end

  // A locked grant stays valid only while its own ID remains eligible
  assign w_grant_idx       = r_lock ? r_lock_idx : w_arb_idx;
  assign w_valid           = r_lock ? w_elig[r_lock_idx] : w_found;
  assign w_active          = rst_ni && !clear_i && w_valid;
  assign out_valid_o       = w_active;
  assign out_id_onehot_o   = w_active ? (NumIds'(1) << w_grant_idx) : '0;
  assign released_onehot_o = out_id_onehot_o & {NumIds{out_ready_i}};

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NumIds; i++) begin
      if (!rst_ni || clear_i || !delay_valid_i[i] || released_onehot_o[i]) begin
        r_cnt[i] <= '0;
      end else if (r_cnt[i] != {CounterWidth{1'b1}}) begin
        r_cnt[i] <= r_cnt[i] + CounterWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (r_lock) begin
      r_lock <= w_valid && !out_ready_i;
    end else if (w_valid && !out_ready_i) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_arb_idx;
    end
  end

`ifdef SIMMEM_DELAY_SCHED_RR_EN
  logic [IdxW-1:0] r_rr_ptr;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      r_rr_ptr <= '0;
    end else if (w_active && out_ready_i) begin
      r_rr_ptr <= wrap_idx(w_grant_idx, 1);
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

endmodule

// File: tb/tb_simmem_delay_release_scheduler.sv
// Randomized bench for simmem_delay_release_scheduler with an in-bench behavioural model and directed pins.
module tb_simmem_delay_release_scheduler;
  localparam int N  = 16;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n, clear, ready;
  logic [N-1:0][DW-1:0] delay;
  logic [N-1:0]        dv;
  logic                ov;
  logic [N-1:0]        oh, rel;

  logic                s_rst_n, s_clear, s_ready;
  logic [1:0][3:0]     s_delay;
  logic [1:0]          s_dv;
  logic                s_ov;
  logic [1:0]          s_oh, s_rel;

  simmem_delay_release_scheduler #(.NumIds(N), .DelayWidth(DW), .CounterWidth(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .delay_i(delay), .delay_valid_i(dv),
    .out_valid_o(ov), .out_id_onehot_o(oh), .out_ready_i(ready), .released_onehot_o(rel)
  );

  simmem_delay_release_scheduler #(.NumIds(2), .DelayWidth(4), .CounterWidth(4)) dut_narrow (
    .clk_i(clk), .rst_ni(s_rst_n), .clear_i(s_clear), .delay_i(s_delay), .delay_valid_i(s_dv),
    .out_valid_o(s_ov), .out_id_onehot_o(s_oh), .out_ready_i(s_ready), .released_onehot_o(s_rel)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: per-ID age of the current head, lock on stalled grant, search pointer.
  int           m_cnt[N];
  bit           m_lock = 1'b0;
  int           m_lid  = 0;
  int           m_rr   = 0;
  logic [N-1:0] e_rel_q = '0;

  always @(negedge clk) begin : model_cmp
    logic [N-1:0] el, eoh, erel;
    logic         ev;
    int           gid, st, j;
    el = '0; eoh = '0; erel = '0; ev = 1'b0; gid = 0;
    for (int i = 0; i < N; i++) el[i] = dv[i] && (m_cnt[i] >= int'(delay[i]));
    if (rst_n && !clear) begin
      if (m_lock) begin
        gid = m_lid;
        ev  = el[m_lid];
      end else begin
`ifdef SIMMEM_DELAY_SCHED_RR_EN
        st = m_rr;
`else
        st = 0;
`endif
        for (int k = 0; k < N; k++) begin
          j = (st + k) % N;
          if (!ev && el[j]) begin
            ev  = 1'b1;
            gid = j;
          end
        end
      end
    end
    if (ev) eoh[gid] = 1'b1;
    if (ev && ready) erel = eoh;
    chk("out_valid", 32'(ov), 32'(ev));
    chk("onehot", 32'(oh), 32'(eoh));
    chk("released", 32'(rel), 32'(erel));
    for (int i = 0; i < N; i++) begin
      if (!rst_n || clear || !dv[i] || erel[i]) m_cnt[i] = 0;
      else if (m_cnt[i] < (2 ** CW) - 1) m_cnt[i] = m_cnt[i] + 1;
    end
    if (!rst_n || clear) begin
      m_lock = 1'b0;
      m_rr   = 0;
    end else begin
      if (ev && !ready) begin
        m_lock = 1'b1;
        m_lid  = gid;
      end else begin
        m_lock = 1'b0;
      end
      if (ev && ready) m_rr = (gid + 1) % N;
    end
    e_rel_q = erel;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 1'b0; dv = '0; delay = '0; ready = 1'b0;
    nxt();
    rst_n = 1'b1;
  endtask

  logic [7:0] t6_v = 8'b1000_1100;

  initial begin
    rst_n = 1'b0; clear = 1'b0; ready = 1'b0; dv = '0; delay = '0;
    s_rst_n = 1'b0; s_clear = 1'b0; s_ready = 1'b0; s_dv = '0; s_delay = '0;
    nxt();
    nxt();

    // Narrow counter saturates at 15 and keeps the stalled grant valid
    s_rst_n = 1'b1; s_dv = 2'b10; s_delay[1] = 4'd15;
    for (int c = 0; c < 56; c++) begin
      @(negedge clk);
      if (c == 14) chk("sat_pre", 32'(s_ov), 32'd0);
      if (c >= 15) begin
        chk("sat_valid", 32'(s_ov), 32'd1);
        chk("sat_oh", 32'(s_oh), 32'd2);
      end
      nxt();
    end
    s_ready = 1'b1;
    @(negedge clk);
    chk("sat_rel", 32'(s_rel), 32'd2);
    nxt();
    s_dv = '0; s_ready = 1'b0;

    // Reset forces outputs low; first cycle after reset grants ID0
    dv = '1; delay = '0; ready = 1'b1; rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_valid", 32'(ov), 32'd0);
      chk("rst_oh", 32'(oh), 32'd0);
      chk("rst_rel", 32'(rel), 32'd0);
      nxt();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_valid", 32'(ov), 32'd1);
    chk("first_oh", 32'(oh), 32'h0001);
    nxt();

    // ID3 with delay 5 releases at cycle 5; its counter restarts for the next head
    do_reset();
    dv = 16'h0008; delay[3] = 8'd5; ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("t2_valid", 32'(ov), 32'(c == 5));
      if (c == 5) chk("t2_rel", 32'(rel), 32'h0008);
      nxt();
    end

    // Locked grant of ID2 survives a stall while ID0 becomes eligible
    do_reset();
    dv = 16'h0084; ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) dv[0] = 1'b1;
      @(negedge clk);
      chk("t3_oh", 32'(oh), 32'h0004);
      nxt();
    end
    ready = 1'b1;
    @(negedge clk);
    chk("t3_rel", 32'(rel), 32'h0004);
    nxt();
    dv[2] = 1'b0; ready = 1'b0;

    // All IDs always eligible with delay 0
    do_reset();
    dv = '1; ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
`ifdef SIMMEM_DELAY_SCHED_RR_EN
      chk("t4_oh", 32'(oh), 32'(16'(1) << (c % 16)));
`else
      chk("t4_oh", 32'(oh), 32'h0001);
`endif
      nxt();
    end

    // Clear during a locked stall beats the handshake and restarts the delay
    do_reset();
    dv = 16'h0020; delay[5] = 8'd2; ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      clear = (c == 4);
      ready = (c == 4);
      @(negedge clk);
      chk("t6_valid", 32'(ov), 32'(t6_v[c]));
      if (t6_v[c]) chk("t6_oh", 32'(oh), 32'h0020);
      if (c == 4) chk("t6_rel", 32'(rel), 32'd0);
      nxt();
    end

    // Randomized traffic; upstream holds each head until the model says it was released
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (dv[i] && e_rel_q[i]) begin
          if ($urandom_range(0, 1) == 1) delay[i] = DW'($urandom_range(0, 7));
          else dv[i] = 1'b0;
        end else if (dv[i]) begin
          if ($urandom_range(0, 49) == 0) dv[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          dv[i]    = 1'b1;
          delay[i] = DW'($urandom_range(0, 7));
        end
      end
      ready = ($urandom_range(0, 9) < 7);
      clear = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
